// File: rtl/retire_trace_unit.sv
// rtl/retire_trace_unit.sv - retirement trace FIFO and performance counters
// Samples write-back each cycle, buffers retire records in a FWFT FIFO, counts events.
module retire_trace_unit #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [XLEN-1:0]          wb_pc,
    input  logic [4:0]               wb_rd,
    input  logic                     wb_reg_write,
    input  logic [XLEN-1:0]          wb_write_data,
    input  logic                     hazard_stall,
    input  logic                     flush,
    input  logic                     trace_enable,
    input  logic                     clear_counters,
    input  logic                     trace_ready,
    output logic                     trace_valid,
    output logic [XLEN-1:0]          trace_pc,
    output logic [4:0]               trace_rd,
    output logic [XLEN-1:0]          trace_data,
    output logic [$clog2(DEPTH):0]   trace_level,
    output logic [63:0]              cycle_count,
    output logic [63:0]              retire_count,
    output logic [31:0]              stall_count,
    output logic [31:0]              flush_count,
    output logic [31:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [XLEN-1:0] r_mem_pc   [DEPTH];
    logic [4:0]      r_mem_rd   [DEPTH];
    logic [XLEN-1:0] r_mem_data [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic [63:0]     r_cycle_count;
    logic [63:0]     r_retire_count;
    logic [31:0]     r_stall_count;
    logic [31:0]     r_flush_count;
    logic [31:0]     r_drop_count;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_drop;
    logic [4:0]      w_rd_eff;
    logic [XLEN-1:0] w_data_eff;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_pop      = !w_empty && trace_ready;
    assign w_push_req = wb_valid && trace_enable;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;

    assign w_rd_eff   = wb_reg_write ? wb_rd : 5'd0;
    assign w_data_eff = (wb_reg_write && (wb_rd != 5'd0)) ? wb_write_data : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= wb_pc;
            r_mem_rd[r_wr_ptr]   <= w_rd_eff;
            r_mem_data[r_wr_ptr] <= w_data_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_counters) begin
            r_cycle_count  <= '0;
            r_retire_count <= '0;
            r_stall_count  <= '0;
            r_flush_count  <= '0;
            r_drop_count   <= '0;
        end else begin
            r_cycle_count  <= r_cycle_count + 64'd1;
            r_retire_count <= r_retire_count + 64'(wb_valid);
            if (hazard_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    // Outputs are gated by occupancy so an empty FIFO never exposes stale storage.
    assign trace_valid  = !w_empty;
    assign trace_pc     = trace_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign trace_rd     = trace_valid ? r_mem_rd[r_rd_ptr]   : 5'd0;
    assign trace_data   = trace_valid ? r_mem_data[r_rd_ptr] : '0;
    assign trace_level  = r_level;
    assign cycle_count  = r_cycle_count;
    assign retire_count = r_retire_count;
    assign stall_count  = r_stall_count;
    assign flush_count  = r_flush_count;
    assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_retire_trace_unit.sv
// tb/tb_retire_trace_unit.sv - self-checking bench for retire_trace_unit
// Directed vector table, hand sequences and a randomized run against a queue model.
module tb_retire_trace_unit;

    localparam int DEPTH = 8;
    localparam int XLEN  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [63:0] wb_write_data;
    logic        hazard_stall;
    logic        flush;
    logic        trace_enable;
    logic        clear_counters;
    logic        trace_ready;
    logic        trace_valid;
    logic [63:0] trace_pc;
    logic [4:0]  trace_rd;
    logic [63:0] trace_data;
    logic [3:0]  trace_level;
    logic [63:0] cycle_count;
    logic [63:0] retire_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic [31:0] drop_count;

    retire_trace_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_write_data(wb_write_data),
        .hazard_stall(hazard_stall), .flush(flush), .trace_enable(trace_enable),
        .clear_counters(clear_counters), .trace_ready(trace_ready),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_rd(trace_rd),
        .trace_data(trace_data), .trace_level(trace_level), .cycle_count(cycle_count),
        .retire_count(retire_count), .stall_count(stall_count), .flush_count(flush_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
    } rec_t;

    rec_t              q[$];
    longint unsigned   m_cycle, m_retire;
    int unsigned       m_stall, m_flush, m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        rec_t h;
        h = '{pc: 64'd0, rd: 5'd0, data: 64'd0};
        if (q.size() > 0) h = q[0];
        chk("valid",  {63'd0, trace_valid}, {63'd0, q.size() > 0});
        chk("pc",     trace_pc, h.pc);
        chk("rd",     {59'd0, trace_rd}, {59'd0, h.rd});
        chk("data",   trace_data, h.data);
        chk("level",  {60'd0, trace_level}, 64'(q.size()));
        chk("cycle",  cycle_count, m_cycle);
        chk("retire", retire_count, m_retire);
        chk("stall",  {32'd0, stall_count}, {32'd0, m_stall});
        chk("flush",  {32'd0, flush_count}, {32'd0, m_flush});
        chk("drop",   {32'd0, drop_count}, {32'd0, m_drop});
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, compare after the edge.
    task automatic step(input logic r, input logic v, input logic [63:0] pc, input logic [4:0] rd,
                        input logic we, input logic [63:0] d, input logic st, input logic fl,
                        input logic en, input logic clr, input logic rdy);
        bit   pop, req, acc;
        rec_t rec;
        rst = r; wb_valid = v; wb_pc = pc; wb_rd = rd; wb_reg_write = we; wb_write_data = d;
        hazard_stall = st; flush = fl; trace_enable = en; clear_counters = clr; trace_ready = rdy;
        if (r) begin
            q.delete();
            m_cycle = 0; m_retire = 0; m_stall = 0; m_flush = 0; m_drop = 0;
        end else begin
            pop = (q.size() > 0) && rdy;
            req = v && en;
            acc = req && ((q.size() < DEPTH) || pop);
            rec.pc   = pc;
            rec.rd   = we ? rd : 5'd0;
            rec.data = (we && rd != 0) ? d : 64'd0;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(rec);
            if (clr) begin
                m_cycle = 0; m_retire = 0; m_stall = 0; m_flush = 0; m_drop = 0;
            end else begin
                m_cycle++;
                m_retire += longint'(v);
                if (st && m_stall != 32'hFFFF_FFFF) m_stall++;
                if (fl && m_flush != 32'hFFFF_FFFF) m_flush++;
                if (req && !acc && m_drop != 32'hFFFF_FFFF) m_drop++;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    endtask

    task automatic push(input logic [63:0] pc, input logic [4:0] rd, input logic we,
                        input logic [63:0] d, input logic rdy);
        step(1'b0, 1'b1, pc, rd, we, d, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    endtask

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] d;
        logic        en;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [4:0]  e_rd;
        logic [63:0] e_data;
        int          e_level;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1, 64'h0,  5'd1, 1, 64'd1,      1, 0, 1, 64'h0,  5'd1, 64'd1, 1};
        vecs[1] = '{1, 64'h4,  5'd2, 1, 64'd1,      1, 0, 1, 64'h0,  5'd1, 64'd1, 2};
        vecs[2] = '{1, 64'h8,  5'd3, 1, 64'd2,      1, 0, 1, 64'h0,  5'd1, 64'd1, 3};
        vecs[3] = '{0, 64'h0,  5'd0, 0, 64'd0,      1, 1, 1, 64'h4,  5'd2, 64'd1, 2};
        vecs[4] = '{0, 64'h0,  5'd0, 0, 64'd0,      1, 1, 1, 64'h8,  5'd3, 64'd2, 1};
        vecs[5] = '{0, 64'h0,  5'd0, 0, 64'd0,      1, 1, 0, 64'h0,  5'd0, 64'd0, 0};
        vecs[6] = '{1, 64'h10, 5'd7, 0, 64'hDEAD,   1, 0, 1, 64'h10, 5'd0, 64'd0, 1};
        vecs[7] = '{1, 64'h14, 5'd0, 1, 64'h55,     1, 1, 1, 64'h14, 5'd0, 64'd0, 1};
        vecs[8] = '{0, 64'h0,  5'd0, 0, 64'd0,      1, 1, 0, 64'h0,  5'd0, 64'd0, 0};
        vecs[9] = '{1, 64'h18, 5'd4, 1, 64'h99,     0, 0, 0, 64'h0,  5'd0, 64'd0, 0};

        step(1'b1, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", {63'd0, trace_valid}, 64'd0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("idle_cycle",  cycle_count, 64'd10);
        chk("idle_retire", retire_count, 64'd0);
        chk("idle_level",  {60'd0, trace_level}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, vecs[i].v, vecs[i].pc, vecs[i].rd, vecs[i].we, vecs[i].d,
                 1'b0, 1'b0, vecs[i].en, 1'b0, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), {63'd0, trace_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_pc", i),    trace_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_rd", i),    {59'd0, trace_rd}, {59'd0, vecs[i].e_rd});
            chk($sformatf("vec%0d_data", i),  trace_data, vecs[i].e_data);
            chk($sformatf("vec%0d_level", i), {60'd0, trace_level}, 64'(vecs[i].e_level));
        end

        // Fill, overflow by two, then push+pop while full.
        step(1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) push(64'h100 + 64'(4 * i), 5'(i + 1), 1'b1, 64'(3 * i), 1'b0);
        chk("full_drop",  {32'd0, drop_count}, 64'd2);
        chk("full_level", {60'd0, trace_level}, 64'd8);
        push(64'h200, 5'd9, 1'b1, 64'h77, 1'b1);
        chk("pp_level", {60'd0, trace_level}, 64'd8);
        chk("pp_drop",  {32'd0, drop_count}, 64'd2);
        chk("pp_head",  trace_pc, 64'h104);

        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b1, i < 2, 1'b1, 1'b0, 1'b0);
        chk("stall4", {32'd0, stall_count}, 64'd4);
        chk("flush2", {32'd0, flush_count}, 64'd2);
        step(1'b0, 1'b1, 64'h300, 5'd5, 1'b1, 64'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_cycle",  cycle_count, 64'd0);
        chk("clr_retire", retire_count, 64'd0);
        chk("clr_stall",  {32'd0, stall_count}, 64'd0);
        chk("clr_level",  {60'd0, trace_level}, 64'd8);
        chk("clr_head",   trace_pc, 64'h104);

        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("drain_level", {60'd0, trace_level}, 64'd5);
        step(1'b1, 1'b1, 64'h400, 5'd1, 1'b1, 64'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("mrst_valid", {63'd0, trace_valid}, 64'd0);
        chk("mrst_level", {60'd0, trace_level}, 64'd0);
        chk("mrst_pc",    trace_pc, 64'd0);
        chk("mrst_cycle", cycle_count, 64'd0);
        push(64'h500, 5'd6, 1'b1, 64'h66, 1'b0);
        chk("post_valid", {63'd0, trace_valid}, 64'd1);
        chk("post_pc",    trace_pc, 64'h500);
        chk("post_data",  trace_data, 64'h66);

        for (int i = 0; i < 3000; i++) begin
            logic rdy;
            rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, {$urandom, $urandom},
                 5'($urandom_range(0, 31)), 1'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_trace_unit.md
# retire_trace_unit

Retirement trace and performance-counter block for the pipelined CPU. Sits directly downstream of the write-back stage. Each cycle it samples the retiring instruction, hazard stall and flush signals, and maintains cycle, retire, stall, flush and drop counters. It buffers per-instruction retire records in a small FIFO, which a bench or debug port drains through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 8 — trace FIFO entries; power of two, ≥ 2.
- XLEN, 64 — datapath width of PC and write data.

Ports (reset is synchronous, active-high, single clock):
- clk  in  1  — system clock; all state updates on the rising edge.
- rst  in  1  — synchronous active-high reset.
- wb_valid  in  1  — a real instruction (not a bubble) retires this cycle.
- wb_pc  in  XLEN  — PC of the retiring instruction.
- wb_rd  in  5  — destination register.
- wb_reg_write  in  1  — retiring instruction writes the register file.
- wb_write_data  in  XLEN  — value written back.
- hazard_stall  in  1  — load-use stall asserted this cycle.
- flush  in  1  — branch/jump flush asserted this cycle.
- trace_enable  in  1  — allows retire records to be pushed.
- clear_counters  in  1  — zeroes all counters.
- trace_ready  in  1  — consumer accepts the head record.
- trace_valid  out  1  — the head record is valid.
- trace_pc  out  XLEN  — head record PC.
- trace_rd  out  5  — head record rd; 0 if the instruction did not write.
- trace_data  out  XLEN  — head record write data; 0 if no write or rd = 0.
- trace_level  out  $clog2(DEPTH)+1  — number of occupied entries.
- cycle_count  out  64  — cycles since reset or clear.
- retire_count  out  64  — retired instructions.
- stall_count  out  32  — stall cycles.
- flush_count  out  32  — flush cycles.
- drop_count  out  32  — records lost because the FIFO was full.

## Operation
- Push request: wb_valid & trace_enable.
- Record written on push: {wb_pc, rd_eff, data_eff}.
  - rd_eff = wb_reg_write ? wb_rd : 0.
  - data_eff = (wb_reg_write && wb_rd ≠ 0) ? wb_write_data : 0.
- Pop: trace_valid & trace_ready.
- Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Simultaneous push and pop on an empty FIFO: the pop cannot occur because trace_valid = 0, so only the push is applied.
- A rejected push increments drop_count and leaves the FIFO unchanged.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- The FIFO is first-word-fall-through: trace_* present the entry at the read pointer whenever trace_valid = 1, and hold it stable until popped.
- trace_* are X-free: they read 0 when the FIFO is empty.
- Counter update rules:
  - cycle_count += 1 every non-reset cycle; 64-bit, wraps.
  - retire_count += wb_valid, independent of trace_enable and FIFO state; wraps.
  - stall_count, flush_count and drop_count saturate at 0xFFFF_FFFF.
- clear_counters zeroes all five counters on the next edge and takes priority over same-cycle increments. It does not affect FIFO contents or pointers.
- rst empties the FIFO, zeroes all counters, and forces every output to 0 on the next edge, including mid-drain and with trace_ready high.

## Timing
- Push at edge N: record appears at the FIFO head (trace_valid = 1 if previously empty) after edge N, visible in cycle N+1.
- Pop at edge N: the next record, or trace_valid = 0, is visible after edge N. trace_level updates on the same edge.
- Counters reflect events sampled at edge N in cycle N+1. There is no combinational path from inputs to counter outputs.
- The only combinational path is from storage to trace_*; no input-to-output combinational path exists.
- Reset values: trace_valid = 0, trace_pc/rd/data = 0, trace_level = 0, all counters = 0.

## Test plan
- Reset then 10 idle cycles with wb_valid = 0 → cycle_count = 10, retire_count = 0, trace_valid = 0, trace_level = 0.
- Push 3 retires with trace_ready = 0: PC 0x0 rd = 1 data = 1; PC 0x4 rd = 2 data = 1; PC 0x8 rd = 3 data = 2 (Fibonacci add). Then raise trace_ready → records drain in order (0x0, 1, 1), (0x4, 2, 1), (0x8, 3, 2); trace_level goes 3→0.
- Retire with wb_reg_write = 0, wb_rd = 7, data = 0xDEAD (a store) → trace_rd = 0, trace_data = 0. A write with rd = 0 also gives trace_data = 0.
- Fill to DEPTH = 8 with trace_ready = 0, then 2 more retires → drop_count = 2, level = 8. Then push and pop in the same cycle while full → accepted, level stays 8, drop_count stays 2.
- hazard_stall high for 4 cycles and flush for 2, then assert clear_counters in a cycle that also has stall and retire → all counters 0 next cycle; FIFO contents intact.
- Assert rst mid-drain with 5 entries and trace_ready = 1 → the next cycle shows trace_valid = 0, level = 0, all counters 0; a subsequent push is visible after one edge.
